ram_arbiter: RTL and testbench

Shares the simple-dual-port block RAM (write port A, read port B, one-cycle registered read) between two requesters: requester 0 is the CPU fetch/decode stage, requester 1 is the data/load path. Each RAM port is arbitrated independently, so a read and a write from different requesters are granted in the same cycle. The block drives the RAM control pins directly and returns read data with a per-requester valid pulse.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/ram_arbiter.sv | 59 +++++
 tb/tb_ram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared widths, requester indices and small helpers for the block-RAM arbiter.
package ram_arb_pkg;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic logic [1:0] idx2oh(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshake plus RAM pin bundle; slave is the arbiter side, master the requester/RAM side.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic [1:0]         req_i;
    logic [1:0]         we_i;
    logic [1:0][ADDR_W-1:0] addr_i;
    logic [1:0][DATA_W-1:0] wdata_i;
    logic [1:0]         gnt_o;
    logic [1:0]         rvalid_o;
    data_t              rdata_o;
    logic               ena;
    logic               wea;
    addr_t              addra;
    data_t              dia;
    logic               enb;
    addr_t              addrb;
    data_t              dob;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, dob,
        output gnt_o, rvalid_o, rdata_o, ena, wea, addra, dia, enb, addrb
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, dob,
        input  gnt_o, rvalid_o, rdata_o, ena, wea, addra, dia, enb, addrb
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way picker: round-robin with a last-granted pointer, or fixed priority to
// requester 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign gnt = {req[1] & ~req[0], req[0]};
`else
    // last = index granted most recently; resets to 1 so requester 0 wins the first tie
    logic last;

    always_comb begin
        gnt = req;
        if (&req)
            gnt = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= 1'b1;
        else if (|req)
            last <= gnt[1];
    end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a simple-dual-port block RAM between fetch and data requesters, one
// arbiter per port. Optional RAM_ARB_FIXED_PRIO_EN makes both ports fixed-priority.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    logic [1:0] wr_req, rd_req;
    logic [1:0] wr_gnt, rd_gnt;
    logic       wr_idx, rd_idx;
    logic       rd_tag;

    assign wr_req = bus.req_i & bus.we_i;
    assign rd_req = bus.req_i & ~bus.we_i;

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));

    assign wr_idx = wr_gnt[REQ_DATA];
    assign rd_idx = rd_gnt[REQ_DATA];

    assign bus.gnt_o   = rst ? (wr_gnt | rd_gnt) : 2'b00;
    assign bus.rdata_o = bus.dob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ena   <= 1'b0;
            bus.wea   <= 1'b0;
            bus.addra <= '0;
            bus.dia   <= '0;
        end else begin
            bus.ena <= |wr_gnt;
            bus.wea <= |wr_gnt;
            if (|wr_gnt) begin
                bus.addra <= bus.addr_i[wr_idx];
                bus.dia   <= bus.wdata_i[wr_idx];
            end
        end
    end

    // rvalid follows enb by one edge, when the RAM has presented dob
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.enb      <= 1'b0;
            bus.addrb    <= '0;
            rd_tag       <= 1'b0;
            bus.rvalid_o <= 2'b00;
        end else begin
            bus.enb      <= |rd_gnt;
            bus.rvalid_o <= bus.enb ? idx2oh(rd_tag) : 2'b00;
            if (|rd_gnt) begin
                bus.addrb <= bus.addr_i[rd_idx];
                rd_tag    <= rd_idx;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked against a queue-free behavioural model and a RAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if bus();
    ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    // block RAM model, with a preload port used before the first request
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    always @(posedge clk) begin
        if (bus.enb) bus.dob <= ram[bus.addrb];
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.ena && bus.wea) ram[bus.addra] <= bus.dia;
    end

    int checks;
    int errors;

    // behavioural model state
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
    logic              rd_last, wr_last;
    logic              pipe_v, pipe_tag;
    logic [DATA_W-1:0] pipe_data;
    logic [1:0]        exp_rv;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        g_rd, g_wr;
    logic [1:0]        act;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] c, input logic last);
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (c == 2'b11) return 2'b01;
`else
        if (c == 2'b11) return last ? 2'b01 : 2'b10;
`endif
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] init_val(input int i);
        case (i)
            3: return 16'h0303;
            4: return 16'h0404;
            5: return 16'h0102;
            7: return 16'h0707;
            default: return 16'hA500 + 16'(i);
        endcase
    endfunction

    task automatic model_reset();
        rd_last = 1'b1;
        wr_last = 1'b1;
        pipe_v  = 1'b0;
        pipe_tag = 1'b0;
        exp_rv  = 2'b00;
        g_rd    = 2'b00;
        g_wr    = 2'b00;
    endtask

    task automatic setreq(input int i, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_i[i]   = r;
        bus.we_i[i]    = w;
        bus.addr_i[i]  = a;
        bus.wdata_i[i] = d;
    endtask

    task automatic idle();
        setreq(0, 1'b0, 1'b0, '0, '0);
        setreq(1, 1'b0, 1'b0, '0, '0);
    endtask

    // one clock cycle: compare DUT against model, then advance the model at the edge
    task automatic tick();
        logic [1:0] rdc, wrc;
        #1;
        rdc  = bus.req_i & ~bus.we_i;
        wrc  = bus.req_i & bus.we_i;
        g_rd = pick(rdc, rd_last);
        g_wr = pick(wrc, wr_last);
        chk("gnt", 32'(bus.gnt_o), 32'(g_rd | g_wr));
        chk("rvalid", 32'(bus.rvalid_o), 32'(exp_rv));
        if (exp_rv != 2'b00) chk("rdata", 32'(bus.rdata_o), 32'(exp_data));
        @(posedge clk);
        exp_rv   = pipe_v ? (pipe_tag ? 2'b10 : 2'b01) : 2'b00;
        exp_data = pipe_data;
        pipe_v   = |g_rd;
        if (|g_rd) begin
            pipe_tag  = g_rd[1];
            pipe_data = model_mem[bus.addr_i[g_rd[1]]];
            rd_last   = g_rd[1];
        end
        if (|g_wr) begin
            model_mem[bus.addr_i[g_wr[1]]] = bus.wdata_i[g_wr[1]];
            wr_last = g_wr[1];
        end
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"},    32'(bus.gnt_o), 32'h0);
        chk({tag, "_ena"},    32'(bus.ena), 32'h0);
        chk({tag, "_wea"},    32'(bus.wea), 32'h0);
        chk({tag, "_enb"},    32'(bus.enb), 32'h0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'h0);
        chk({tag, "_addra"},  32'(bus.addra), 32'h0);
        chk({tag, "_addrb"},  32'(bus.addrb), 32'h0);
        chk({tag, "_dia"},    32'(bus.dia), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        setreq(0, 1'b1, 1'b0, 10'd5, 16'h0);
        #1;
        reset_checks("rst");
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        act    = 2'b00;
        rst    = 1'b1;
        pl_en  = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        idle();
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = ADDR_W'(i);
            pl_data = init_val(i);
            model_mem[i] = init_val(i);
        end
        @(negedge clk);
        pl_en = 1'b0;
        setreq(0, 1'b1, 1'b0, 10'd5, 16'h0);
        #1;
        reset_checks("init");
        idle();
        @(negedge clk);
        rst = 1'b1;

        // single fetch read of address 5
        setreq(0, 1'b1, 1'b0, 10'd5, 16'h0);
        #1 chk("t1_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        idle();
        tick();
        chk("t1_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("t1_rdata", 32'(bus.rdata_o), 32'h0102);
        tick();

        // both requesters read continuously: alternating grants and tags
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                setreq(0, 1'b1, 1'b0, 10'd3, 16'h0);
                setreq(1, 1'b1, 1'b0, 10'd4, 16'h0);
                #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
                chk("t2_gnt", 32'(bus.gnt_o), 32'h1);
`else
                chk("t2_gnt", 32'(bus.gnt_o), (k % 2 != 0) ? 32'h2 : 32'h1);
`endif
            end else begin
                idle();
            end
            tick();
            if (k >= 1 && k <= 4) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                chk("t2_rvalid", 32'(bus.rvalid_o), 32'h1);
                chk("t2_rdata", 32'(bus.rdata_o), 32'h0303);
`else
                chk("t2_rvalid", 32'(bus.rvalid_o), ((k - 1) % 2 != 0) ? 32'h2 : 32'h1);
                chk("t2_rdata", 32'(bus.rdata_o), ((k - 1) % 2 != 0) ? 32'h0404 : 32'h0303);
`endif
            end
        end

        // same-address read and write in the same cycle, then a later read
        setreq(0, 1'b1, 1'b0, 10'd7, 16'h0);
        setreq(1, 1'b1, 1'b1, 10'd7, 16'hBEEF);
        #1 chk("t3_gnt", 32'(bus.gnt_o), 32'h3);
        tick();
        idle();
        tick();
        chk("t3_rvalid_old", 32'(bus.rvalid_o), 32'h1);
        chk("t3_rdata_old", 32'(bus.rdata_o), 32'h0707);
        setreq(0, 1'b1, 1'b0, 10'd7, 16'h0);
        tick();
        idle();
        tick();
        chk("t3_rvalid_new", 32'(bus.rvalid_o), 32'h1);
        chk("t3_rdata_new", 32'(bus.rdata_o), 32'hBEEF);

        // simultaneous writes
        setreq(0, 1'b1, 1'b1, 10'd1, 16'h1111);
        setreq(1, 1'b1, 1'b1, 10'd2, 16'h2222);
        #1 chk("t4_gnt_first", 32'(bus.gnt_o), 32'h1);
        tick();
        setreq(0, 1'b0, 1'b0, '0, '0);
        #1 chk("t4_gnt_second", 32'(bus.gnt_o), 32'h2);
        tick();
        idle();
        tick();
        tick();
        chk("t4_ram1", 32'(ram[1]), 32'h1111);
        chk("t4_ram2", 32'(ram[2]), 32'h2222);

        // reset in the cycle after a read grant
        setreq(0, 1'b1, 1'b0, 10'd5, 16'h0);
        tick();
        idle();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_rvalid_dropped", 32'(bus.rvalid_o), 32'h0);
        end
        setreq(0, 1'b1, 1'b0, 10'd3, 16'h0);
        setreq(1, 1'b1, 1'b0, 10'd4, 16'h0);
        #1 chk("t5_first_tie", 32'(bus.gnt_o), 32'h1);
        tick();
        idle();
        tick();
        tick();

        // three cycles of continuous reads from both
        for (int k = 0; k < 3; k++) begin
            setreq(0, 1'b1, 1'b0, 10'd3, 16'h0);
            setreq(1, 1'b1, 1'b0, 10'd4, 16'h0);
            #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            chk("t6_gnt", 32'(bus.gnt_o), 32'h1);
`else
            chk("t6_gnt", 32'(bus.gnt_o), (k % 2 == 0) ? 32'h2 : 32'h1);
`endif
            tick();
        end
        idle();
        tick();
        tick();

        // randomized traffic
        act = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                idle();
                act = 2'b00;
                do_reset();
            end
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (g_rd[i] || g_wr[i])) act[i] = 1'b0;
                if (!act[i] && $urandom_range(0, 9) < 6) begin
                    act[i] = 1'b1;
                    bus.we_i[i]    = 1'($urandom_range(0, 1));
                    bus.addr_i[i]  = ADDR_W'($urandom_range(0, 15));
                    bus.wdata_i[i] = DATA_W'($urandom);
                end
                bus.req_i[i] = act[i];
            end
            tick();
        end
        idle();
        tick();
        tick();
        tick();
        for (int a = 0; a < 16; a++)
            chk($sformatf("ram_content_%0d", a), 32'(ram[a]), 32'(model_mem[a]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
